enc_iter: RTL and testbench

//  Sequential, parametrised successor to the combinational one-hot encoder.

---
 rtl/enc_iter.sv | 165 ++++++++++++++++
 tb/tb_enc_iter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/enc_iter.sv
// enc_iter: drains a multi-hot W-bit vector as a stream of set-bit indices.
// A vector is accepted over a valid/ready handshake, then one index is
// emitted per output beat (ascending, or descending when MSB_FIRST=1), with
// the final beat flagged. An all-zero vector produces a single "none" beat.
//
// Optional feature macro: ENC_ITER_CNT_EN
//   When defined, adds out_cnt_o carrying the popcount of the accepted vector.
//
// FSM states
//   state | meaning
//   IDLE  | no vector held; ready for a new input vector
//   BUSY  | draining msk_q, one index per beat; out_vld_o high
module enc_iter #(
  parameter int W         = 32,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IW       = $clog2(W)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  in_vld_i,
  input  logic [W-1:0]          in_x_i,
  output logic                  in_rdy_o,
  output logic                  out_vld_o,
  output logic [IW-1:0]         out_idx_o,
  output logic                  out_last_o,
  output logic                  out_none_o,
`ifdef ENC_ITER_CNT_EN
  output logic [$clog2(W+1)-1:0] out_cnt_o,
`endif
  input  logic                  out_rdy_i
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   msk_q, msk_d;
  logic           none_q, none_d;
  logic [W-1:0]   sel;
  logic [IW-1:0]  idx;
  logic           onehot;
  logic           busy;
  logic           last;
  logic           xfer;
  logic           accept;

  // Priority pick of the bit to emit next; sel is its one-hot mask so the
  // same decision clears the bit after transfer.
  always_comb begin
    idx = '0;
    sel = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < W; i++) begin
        if (msk_q[i]) begin
          idx    = IW'(i);
          sel    = '0;
          sel[i] = 1'b1;
        end
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (msk_q[i]) begin
          idx    = IW'(i);
          sel    = '0;
          sel[i] = 1'b1;
        end
      end
    end
  end

  // Handshake and beat qualifiers.
  always_comb begin
    onehot     = (msk_q != '0) && ((msk_q & (msk_q - W'(1))) == '0);
    busy       = (state_q == BUSY);
    last       = none_q | onehot;
    xfer       = busy & out_rdy_i;
    in_rdy_o   = ~busy | (last & out_rdy_i);
    accept     = in_vld_i & in_rdy_o;
    out_vld_o  = busy;
    out_idx_o  = busy ? idx : '0;
    out_last_o = busy & last;
    out_none_o = busy & none_q;
  end

  // Next-state logic: load on accept, clear emitted bit on non-last beats,
  // drop to IDLE (or reload back-to-back) on the last beat.
  always_comb begin
    state_d = state_q;
    msk_d   = msk_q;
    none_d  = none_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          msk_d   = in_x_i;
          none_d  = ~|in_x_i;
        end
      end
      BUSY: begin
        if (xfer) begin
          if (last) begin
            if (accept) begin
              state_d = BUSY;
              msk_d   = in_x_i;
              none_d  = ~|in_x_i;
            end else begin
              state_d = IDLE;
              msk_d   = '0;
              none_d  = 1'b0;
            end
          end else begin
            msk_d = msk_q & ~sel;
          end
        end
      end
      default: begin
        state_d = IDLE;
        msk_d   = '0;
        none_d  = 1'b0;
      end
    endcase
  end

  // State, residual mask and none flag registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      msk_q   <= '0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msk_q   <= msk_d;
      none_q  <= none_d;
    end
  end

`ifdef ENC_ITER_CNT_EN
  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] pop;

  // Popcount of the incoming vector, only consumed on accept.
  always_comb begin
    pop = '0;
    for (int i = 0; i < W; i++) begin
      pop = pop + CW'(in_x_i[i]);
    end
  end

  // Count is captured at accept and held for every beat of that vector.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= pop;
    end
  end

  assign out_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_enc_iter.sv
// Directed bench for enc_iter: one ascending and one descending instance
// (W=8) driven by the same stimulus, expected values written by hand.
`timescale 1ns/1ps
module tb_enc_iter;

  logic       clk;
  logic       arst;
  logic       in_vld_i;
  logic [7:0] in_x_i;
  logic       out_rdy_i;

  logic       in_rdy_l, vld_l, last_l, none_l;
  logic [2:0] idx_l;
  logic       in_rdy_m, vld_m, last_m, none_m;
  logic [2:0] idx_m;
`ifdef ENC_ITER_CNT_EN
  logic [3:0] cnt_l, cnt_m;
`endif

  int n_chk = 0;
  int n_err = 0;

  enc_iter #(.W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .arst       (arst),
    .in_vld_i   (in_vld_i),
    .in_x_i     (in_x_i),
    .in_rdy_o   (in_rdy_l),
    .out_vld_o  (vld_l),
    .out_idx_o  (idx_l),
    .out_last_o (last_l),
    .out_none_o (none_l),
`ifdef ENC_ITER_CNT_EN
    .out_cnt_o  (cnt_l),
`endif
    .out_rdy_i  (out_rdy_i)
  );

  enc_iter #(.W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .arst       (arst),
    .in_vld_i   (in_vld_i),
    .in_x_i     (in_x_i),
    .in_rdy_o   (in_rdy_m),
    .out_vld_o  (vld_m),
    .out_idx_o  (idx_m),
    .out_last_o (last_m),
    .out_none_o (none_m),
`ifdef ENC_ITER_CNT_EN
    .out_cnt_o  (cnt_m),
`endif
    .out_rdy_i  (out_rdy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock: inputs are changed only at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Check a live beat on both instances; sampled 1ns after the falling edge.
  task automatic beat(input string tag, input int il, input int im,
                      input bit last, input bit none, input bit rdy);
    #1;
    chk({tag, ".vld_l"},  vld_l,    1);
    chk({tag, ".vld_m"},  vld_m,    1);
    chk({tag, ".idx_l"},  idx_l,    il);
    chk({tag, ".idx_m"},  idx_m,    im);
    chk({tag, ".last_l"}, last_l,   last);
    chk({tag, ".last_m"}, last_m,   last);
    chk({tag, ".none_l"}, none_l,   none);
    chk({tag, ".none_m"}, none_m,   none);
    chk({tag, ".rdy_l"},  in_rdy_l, rdy);
    chk({tag, ".rdy_m"},  in_rdy_m, rdy);
  endtask

  task automatic idle(input string tag);
    #1;
    chk({tag, ".vld_l"},  vld_l,    0);
    chk({tag, ".vld_m"},  vld_m,    0);
    chk({tag, ".idx_l"},  idx_l,    0);
    chk({tag, ".last_l"}, last_l,   0);
    chk({tag, ".none_l"}, none_l,   0);
    chk({tag, ".rdy_l"},  in_rdy_l, 1);
    chk({tag, ".rdy_m"},  in_rdy_m, 1);
  endtask

  // Present a vector for exactly one accept edge.
  task automatic send(input logic [7:0] x);
    in_vld_i = 1'b1;
    in_x_i   = x;
    tick();
    in_vld_i = 1'b0;
    in_x_i   = 8'h5A;
  endtask

  initial begin
    arst      = 1'b1;
    in_vld_i  = 1'b0;
    in_x_i    = 8'h00;
    out_rdy_i = 1'b1;
    #2;
    idle("reset");
`ifdef ENC_ITER_CNT_EN
    chk("reset.cnt", cnt_l, 0);
`endif
    @(negedge clk);
    arst = 1'b0;
    tick();
    idle("post_reset");

    // 1/2: 1010_0110 -> ascending 1,2,5,7 / descending 7,5,2,1
    send(8'hA6);
    beat("t1.b0", 1, 7, 0, 0, 0);
`ifdef ENC_ITER_CNT_EN
    chk("t1.cnt", cnt_l, 4);
`endif
    tick(); beat("t1.b1", 2, 5, 0, 0, 0);
    tick(); beat("t1.b2", 5, 2, 0, 0, 0);
    tick(); beat("t1.b3", 7, 1, 1, 0, 1);
    tick(); idle("t1.end");

    // 3: all-zero vector
    send(8'h00);
    beat("t3.b0", 0, 0, 1, 1, 1);
`ifdef ENC_ITER_CNT_EN
    chk("t3.cnt", cnt_l, 0);
`endif
    tick(); idle("t3.end");

    // 4: back-to-back single-bit vectors, no bubble
    send(8'h01);
    in_vld_i = 1'b1;
    in_x_i   = 8'h80;
    beat("t4.b0", 0, 0, 1, 0, 1);
    tick();
    in_vld_i = 1'b0;
    beat("t4.b1", 7, 7, 1, 0, 1);
    tick(); idle("t4.end");

    // 5: 8'hFF with two stall cycles before each transfer
    send(8'hFF);
    for (int k = 0; k < 8; k++) begin
      out_rdy_i = 1'b0;
      beat($sformatf("t5.s%0d", k), k, 7 - k, k == 7, 0, 0);
      tick();
      beat($sformatf("t5.h%0d", k), k, 7 - k, k == 7, 0, 0);
      tick();
      out_rdy_i = 1'b1;
      beat($sformatf("t5.x%0d", k), k, 7 - k, k == 7, 0, k == 7);
      tick();
    end
    idle("t5.end");

    // 6: reset after two beats of 8'hFF, then a clean vector
    send(8'hFF);
    beat("t6.b0", 0, 7, 0, 0, 0);
`ifdef ENC_ITER_CNT_EN
    chk("t6.cnt0", cnt_l, 8);
    chk("t6.cntm", cnt_m, 8);
`endif
    tick(); beat("t6.b1", 1, 6, 0, 0, 0);
    tick(); beat("t6.b2", 2, 5, 0, 0, 0);
    arst = 1'b1;
    idle("t6.rst");
`ifdef ENC_ITER_CNT_EN
    chk("t6.cntr", cnt_l, 0);
`endif
    tick();
    idle("t6.rst2");
    arst = 1'b0;
    tick();
    send(8'h24);
    beat("t6.n0", 2, 5, 0, 0, 0);
    tick(); beat("t6.n1", 5, 2, 1, 0, 1);
    tick(); idle("t6.end");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
